td4_prog_sequencer: RTL and testbench

- Program-store and run controller for the TD4 CPU core.
- Holds the 16 x 8-bit program. Loads it from the host via a valid/ready byte stream.
- Presents the instruction at the CPU's current PC as opcode[3:0] / immediate[7:4].
- Sequences CPU execution with a clock-enable: idle, free-run, single-step, halt.

---
 rtl/td4_seq_pkg.sv | 17 +
 rtl/td4_prog_mem.sv | 28 ++
 rtl/td4_prog_sequencer.sv | 155 +++++++++++++++
 tb/tb_td4_prog_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_seq_pkg.sv
// Shared types and constants for the TD4 program sequencer.
package td4_seq_pkg;

    localparam int unsigned PROG_DEPTH = 16;
    localparam int unsigned PROG_AW    = 4;

    localparam logic [3:0] OP_JMP = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/td4_prog_mem.sv
// 16 x 8-bit program store: synchronous write, asynchronous read, synchronous clear.
module td4_prog_mem
    import td4_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [PROG_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [PROG_AW-1:0] pc_in,
    output logic [7:0]         rdata
);

    logic [7:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[pc_in];

endmodule

// File: rtl/td4_prog_sequencer.sv
// TD4 program-store loader and run controller (idle / load / run / step / halt).
// Optional self-loop halt detection enabled by defining TD4_SELF_LOOP_HALT_EN.
module td4_prog_sequencer
    import td4_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_load,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       run,
    input  logic       step,
    input  logic       halt_req,
    input  logic [3:0] pc_in,
    output logic [3:0] instr_opcode,
    output logic [3:0] instr_imm,
    output logic       cpu_en,
    output logic [2:0] state_o,
    output logic       load_done,
    output logic [7:0] cycle_cnt
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    seq_state_t         state, state_next;
    logic [PROG_AW-1:0] wr_ptr;
    logic [7:0]         div_cnt;
    logic [7:0]         rdata;
    logic               mem_we;
    logic               clr_load;
    logic               clr_div;
    logic               set_done;
    logic               self_loop;

    td4_prog_mem u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .pc_in (pc_in),
        .rdata (rdata)
    );

    assign instr_opcode = rdata[3:0];
    assign instr_imm    = rdata[7:4];
    assign state_o      = state;

`ifdef TD4_SELF_LOOP_HALT_EN
    // A JMP to its own address means the CPU can never make progress.
    assign self_loop = (instr_opcode == OP_JMP) && (instr_imm == pc_in);
`else
    assign self_loop = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cpu_en     = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        clr_load   = 1'b0;
        clr_div    = 1'b0;
        set_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (halt_req) begin
                    state_next = S_HALT;
                end else if (mode_load) begin
                    state_next = S_LOAD;
                    clr_load   = 1'b1;
                end else if (step) begin
                    state_next = S_STEP;
                end else if (run) begin
                    state_next = S_RUN;
                    clr_div    = 1'b1;
                end
            end
            S_LOAD: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                if (wr_valid && (wr_ptr == 4'hF)) begin
                    set_done   = 1'b1;
                    state_next = S_IDLE;
                end else if (!mode_load) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_next = S_HALT;
                end else if (!run) begin
                    state_next = S_IDLE;
                end else if (self_loop) begin
                    state_next = S_HALT;
                end else begin
                    cpu_en = (div_cnt == DIV_LAST);
                end
            end
            S_STEP: begin
                if (halt_req) begin
                    state_next = S_HALT;
                end else begin
                    cpu_en     = 1'b1;
                    state_next = self_loop ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                if (!halt_req && !run && !step) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            div_cnt   <= '0;
            load_done <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state <= state_next;

            if (clr_load) begin
                wr_ptr <= '0;
            end else if (mem_we) begin
                wr_ptr <= wr_ptr + 4'd1;
            end

            if (clr_load) begin
                load_done <= 1'b0;
            end else if (set_done) begin
                load_done <= 1'b1;
            end

            if (clr_div) begin
                div_cnt <= '0;
            end else if (state == S_RUN) begin
                div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
            end

            if (clr_load) begin
                cycle_cnt <= '0;
            end else if (cpu_en && (cycle_cnt != 8'hFF)) begin
                cycle_cnt <= cycle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_td4_prog_sequencer.sv
// Self-checking bench: per-cycle reference model plus directed literal checks.
module tb_td4_prog_sequencer;

    localparam int unsigned CLK_DIV = 3;
    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_STEP = 3, ST_HALT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_load = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       halt_req = 1'b0;
    logic [3:0] pc_in = 4'h0;
    logic       wr_ready;
    logic [3:0] instr_opcode;
    logic [3:0] instr_imm;
    logic       cpu_en;
    logic [2:0] state_o;
    logic       load_done;
    logic [7:0] cycle_cnt;

    always #5 clk = ~clk;

    td4_prog_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_load    (mode_load),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .run          (run),
        .step         (step),
        .halt_req     (halt_req),
        .pc_in        (pc_in),
        .instr_opcode (instr_opcode),
        .instr_imm    (instr_imm),
        .cpu_en       (cpu_en),
        .state_o      (state_o),
        .load_done    (load_done),
        .cycle_cnt    (cycle_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: abstract state number, program image, RUN-cycle age.
    int         m_state = ST_IDLE;
    int         m_ptr = 0;
    logic [7:0] m_mem [16];
    bit         m_done = 1'b0;
    int         m_cnt = 0;
    int         m_age = 0;
    bit         m_valid = 1'b0;

    function automatic bit m_spin();
`ifdef TD4_SELF_LOOP_HALT_EN
        return (m_mem[pc_in][3:0] == 4'hF) && (m_mem[pc_in][7:4] == pc_in);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_en();
        case (m_state)
            ST_RUN:  return !halt_req && run && !m_spin() && (((m_age + 1) % CLK_DIV) == 0);
            ST_STEP: return !halt_req;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit en;
        en = m_en();
        if (!rst_n) begin
            m_state = ST_IDLE;
            m_ptr   = 0;
            m_done  = 1'b0;
            m_cnt   = 0;
            m_age   = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_valid = 1'b1;
        end else begin
            if (en && m_cnt < 255) m_cnt++;
            case (m_state)
                ST_IDLE: begin
                    if (halt_req) m_state = ST_HALT;
                    else if (mode_load) begin
                        m_state = ST_LOAD; m_ptr = 0; m_done = 1'b0; m_cnt = 0;
                    end else if (step) m_state = ST_STEP;
                    else if (run) begin
                        m_state = ST_RUN; m_age = 0;
                    end
                end
                ST_LOAD: begin
                    if (!mode_load) m_state = ST_IDLE;
                    if (wr_valid) begin
                        m_mem[m_ptr] = wr_data;
                        if (m_ptr == 15) begin
                            m_done = 1'b1; m_state = ST_IDLE;
                        end
                        m_ptr = (m_ptr + 1) % 16;
                    end
                end
                ST_RUN: begin
                    m_age++;
                    if (halt_req) m_state = ST_HALT;
                    else if (!run) m_state = ST_IDLE;
                    else if (m_spin()) m_state = ST_HALT;
                end
                ST_STEP: begin
                    if (halt_req || m_spin()) m_state = ST_HALT;
                    else m_state = ST_IDLE;
                end
                ST_HALT: begin
                    if (!halt_req && !run && !step) m_state = ST_IDLE;
                end
                default: m_state = ST_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", state_o, m_state);
            check("model_wr_ready", wr_ready, (m_state == ST_LOAD));
            check("model_cpu_en", cpu_en, m_en());
            check("model_load_done", load_done, m_done);
            check("model_cycle_cnt", cycle_cnt, m_cnt);
            check("model_opcode", instr_opcode, m_mem[pc_in][3:0]);
            check("model_imm", instr_imm, m_mem[pc_in][7:4]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] pat;

        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_state", state_o, ST_IDLE);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_cpu_en", cpu_en, 0);

        // Full 16-byte load of 00..0F
        mode_load = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            #1;
            check("load_wr_ready", wr_ready, 1);
            tick();
        end
        mode_load = 1'b0;
        wr_valid  = 1'b0;
        pc_in     = 4'd5;
        #1;
        check("full_load_done", load_done, 1);
        check("full_load_state", state_o, ST_IDLE);
        check("full_pc5_opcode", instr_opcode, 4'h5);
        check("full_pc5_imm", instr_imm, 4'h0);

        // Reset clears memory; then partial load aborted after 6 bytes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mem_clear", {instr_imm, instr_opcode}, 8'h00);
        mode_load = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hC1 + i);
            tick();
        end
        mode_load = 1'b0;
        wr_valid  = 1'b0;
        tick();
        check("partial_state", state_o, ST_IDLE);
        check("partial_load_done", load_done, 0);
        pc_in = 4'd3;
        #1;
        check("partial_pc3_opcode", instr_opcode, 4'h4);
        check("partial_pc3_imm", instr_imm, 4'hC);
        pc_in = 4'd9;
        #1;
        check("partial_pc9_word", {instr_imm, instr_opcode}, 8'h00);

        // Free run with CLK_DIV=3 for 12 cycles
        run = 1'b1;
        tick();
        pat = '0;
        for (int k = 0; k < 12; k++) begin
            pat[k] = cpu_en;
            tick();
        end
        check("run_en_pattern", pat, 12'b100100100100);
        check("run_cycle_cnt", cycle_cnt, 4);
        run = 1'b0;
        #1;
        check("run_stop_en", cpu_en, 0);
        tick();
        check("run_stop_state", state_o, ST_IDLE);

        // Single step
        step = 1'b1;
        tick();
        step = 1'b0;
        #1;
        check("step_state", state_o, ST_STEP);
        check("step_en", cpu_en, 1);
        tick();
        check("step_back_idle", state_o, ST_IDLE);
        check("step_cycle_cnt", cycle_cnt, 5);

        // Step with halt_req goes to HALT
        step     = 1'b1;
        halt_req = 1'b1;
        tick();
        check("step_halt_state", state_o, ST_HALT);
        check("step_halt_en", cpu_en, 0);
        step     = 1'b0;
        halt_req = 1'b0;
        tick();
        check("halt_release", state_o, ST_IDLE);

        // Halt arriving on a cycle where an enable is due
        run = 1'b1;
        repeat (3) tick();
        check("due_en", cpu_en, 1);
        halt_req = 1'b1;
        #1;
        check("due_halt_blocks_en", cpu_en, 0);
        tick();
        check("due_halt_state", state_o, ST_HALT);
        check("due_halt_cnt", cycle_cnt, 5);
        halt_req = 1'b0;
        tick();
        check("halt_hold_run", state_o, ST_HALT);
        run  = 1'b0;
        step = 1'b1;
        tick();
        check("halt_hold_step", state_o, ST_HALT);
        step = 1'b0;
        tick();
        check("halt_exit", state_o, ST_IDLE);

        // Program with a self-loop JMP at address 7
        mode_load = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i == 7) ? 8'h7F : 8'(i);
            tick();
        end
        mode_load = 1'b0;
        wr_valid  = 1'b0;
        pc_in     = 4'd7;
        #1;
        check("loop_pc7_opcode", instr_opcode, 4'hF);
        check("loop_pc7_imm", instr_imm, 4'h7);
        check("loop_cnt_cleared", cycle_cnt, 0);
        run = 1'b1;
        tick();
        check("loop_run_entered", state_o, ST_RUN);
`ifdef TD4_SELF_LOOP_HALT_EN
        check("loop_en_blocked", cpu_en, 0);
        tick();
        check("loop_halted", state_o, ST_HALT);
        run = 1'b0;
        tick();
        check("loop_halt_exit", state_o, ST_IDLE);
`else
        repeat (800) tick();
        check("loop_still_run", state_o, ST_RUN);
        check("loop_cnt_saturated", cycle_cnt, 255);
        run = 1'b0;
        tick();
        check("loop_stop_idle", state_o, ST_IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
